// File: rtl/axi_stream_insert_header_pkg.sv
// Shared definitions for the header-insertion block: FSM encoding and
// byte-count sizing helpers.
package axi_stream_insert_header_pkg;

   // Default data bus width in bits.
   localparam int AXIS_DATA_WD = 32;

   // Packet-level state of the inserter.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   // Width needed to hold a byte count from 0 to n_bytes inclusive.
   function automatic int count_width(input int n_bytes);
      return $clog2(n_bytes + 1);
   endfunction

endpackage

// File: rtl/axis_keep_count.sv
// Combinational popcount of an AXI-Stream keep vector.
module axis_keep_count
   import axi_stream_insert_header_pkg::*;
#(
   parameter int KEEP_WD = 4,
   parameter int CNT_WD  = count_width(KEEP_WD)
)(
   input  logic [KEEP_WD-1:0] keep,
   output logic [CNT_WD-1:0]  count
);

   // Sum the enable bits; only the number of valid bytes matters downstream.
   always_comb begin
      count = '0;
      for (int i = 0; i < KEEP_WD; i++) begin
         count = count + CNT_WD'(keep[i]);
      end
   end

endmodule

// File: rtl/axi_stream_insert_header.sv
// Prepends the valid bytes of a per-packet header to an AXI-Stream packet and
// repacks header + payload into full-width, MSB-first output beats.
module axi_stream_insert_header
   import axi_stream_insert_header_pkg::*;
#(
   parameter int DATA_WD      = AXIS_DATA_WD,
   parameter int DATA_BYTE_WD = DATA_WD / 8
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   input  logic                    valid_insert,
   output logic                    ready_insert,
   input  logic [DATA_WD-1:0]      header_insert,
   input  logic [DATA_BYTE_WD-1:0] keep_insert,
   output logic                    valid_out,
   input  logic                    ready_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out
);

   localparam int CNT_WD = count_width(DATA_BYTE_WD);
   localparam int SUM_WD = CNT_WD + 1;

   state_t                  state_reg, state_next;
   logic [DATA_WD-1:0]      res_data_reg, res_data_next;
   logic [CNT_WD-1:0]       res_cnt_reg, res_cnt_next;
   logic                    valid_out_reg, valid_out_next;
   logic [DATA_WD-1:0]      data_out_reg, data_out_next;
   logic [DATA_BYTE_WD-1:0] keep_out_reg, keep_out_next;
   logic                    last_out_reg, last_out_next;

   logic [CNT_WD-1:0]       beat_cnt;
   logic [CNT_WD-1:0]       hdr_cnt;
   logic [DATA_WD-1:0]      beat_masked;
   logic [DATA_WD-1:0]      hdr_aligned;
   logic [2*DATA_WD-1:0]    byte_cat;
   logic [SUM_WD-1:0]       byte_sum;
   logic [DATA_BYTE_WD-1:0] keep_of_sum;
   logic [DATA_BYTE_WD-1:0] keep_of_res;
   logic                    out_free;

   axis_keep_count #(.KEEP_WD(DATA_BYTE_WD), .CNT_WD(CNT_WD)) u_beat_count (
      .keep  (keep_in),
      .count (beat_cnt)
   );

   axis_keep_count #(.KEEP_WD(DATA_BYTE_WD), .CNT_WD(CNT_WD)) u_hdr_count (
      .keep  (keep_insert),
      .count (hdr_cnt)
   );

   // Per-byte helpers: zero disabled payload bytes so padding comes out as 0,
   // and expand byte counts into MSB-aligned keep masks.
   for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_byte
      assign beat_masked[8*gi +: 8]             = keep_in[gi] ? data_in[8*gi +: 8] : 8'h00;
      assign keep_of_sum[DATA_BYTE_WD-1-gi]     = (SUM_WD'(gi) < byte_sum);
      assign keep_of_res[DATA_BYTE_WD-1-gi]     = (CNT_WD'(gi) < res_cnt_reg);
   end

   // The residual is held MSB-aligned; the header's LSB-aligned bytes are
   // shifted up so its first valid byte sits in the top lane.
   assign hdr_aligned = header_insert << (8 * (DATA_BYTE_WD - int'(hdr_cnt)));

   // Residual bytes followed directly by the beat's bytes; the upper word is
   // the next output beat and the lower word is what carries over.
   assign byte_cat = {res_data_reg, {DATA_WD{1'b0}}}
                   | ({beat_masked, {DATA_WD{1'b0}}} >> (8 * int'(res_cnt_reg)));
   assign byte_sum = SUM_WD'(res_cnt_reg) + SUM_WD'(beat_cnt);

   assign out_free = !valid_out_reg || ready_out;

   // Next-state, handshake and datapath decisions.
   always_comb begin
      state_next     = state_reg;
      res_data_next  = res_data_reg;
      res_cnt_next   = res_cnt_reg;
      valid_out_next = valid_out_reg && !ready_out;
      data_out_next  = data_out_reg;
      keep_out_next  = keep_out_reg;
      last_out_next  = last_out_reg;
      ready_in       = 1'b0;
      ready_insert   = 1'b0;

      case (state_reg)
         IDLE: begin
            ready_insert = 1'b1;
            if (valid_insert) begin
               res_data_next = hdr_aligned;
               res_cnt_next  = hdr_cnt;
               state_next    = STREAM;
            end
         end

         STREAM: begin
            ready_in = out_free;
            if (valid_in && out_free) begin
               valid_out_next = 1'b1;
               data_out_next  = byte_cat[2*DATA_WD-1 -: DATA_WD];
               if (byte_sum >= SUM_WD'(DATA_BYTE_WD)) begin
                  keep_out_next = '1;
                  res_data_next = byte_cat[DATA_WD-1:0];
                  res_cnt_next  = CNT_WD'(byte_sum - SUM_WD'(DATA_BYTE_WD));
               end else begin
                  keep_out_next = keep_of_sum;
                  res_data_next = '0;
                  res_cnt_next  = '0;
               end
               last_out_next = 1'b0;
               if (last_in) begin
                  if (byte_sum <= SUM_WD'(DATA_BYTE_WD)) begin
                     last_out_next = 1'b1;
                     res_data_next = '0;
                     res_cnt_next  = '0;
                     state_next    = IDLE;
                  end else begin
                     state_next    = FLUSH;
                  end
               end
            end
         end

         FLUSH: begin
            if (out_free) begin
               valid_out_next = 1'b1;
               data_out_next  = res_data_reg;
               keep_out_next  = keep_of_res;
               last_out_next  = 1'b1;
               res_data_next  = '0;
               res_cnt_next   = '0;
               state_next     = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Residual buffer and output register; reset drops any packet in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_data_reg  <= '0;
         res_cnt_reg   <= '0;
         valid_out_reg <= 1'b0;
         data_out_reg  <= '0;
         keep_out_reg  <= '0;
         last_out_reg  <= 1'b0;
      end else begin
         res_data_reg  <= res_data_next;
         res_cnt_reg   <= res_cnt_next;
         valid_out_reg <= valid_out_next;
         data_out_reg  <= data_out_next;
         keep_out_reg  <= keep_out_next;
         last_out_reg  <= last_out_next;
      end
   end

   assign valid_out = valid_out_reg;
   assign data_out  = data_out_reg;
   assign keep_out  = keep_out_reg;
   assign last_out  = last_out_reg;

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for axi_stream_insert_header: hand-computed packets, a
// random-backpressure byte-stream check, and a mid-packet reset.
module tb_axi_stream_insert_header;

   typedef struct packed {
      logic        last;
      logic [3:0]  keep;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic        ready_in;
   logic [31:0] data_in;
   logic [3:0]  keep_in;
   logic        last_in;
   logic        valid_insert;
   logic        ready_insert;
   logic [31:0] header_insert;
   logic [3:0]  keep_insert;
   logic        valid_out;
   logic        ready_out;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;

   int    tests_run    = 0;
   int    tests_failed = 0;
   logic  rand_ready   = 1'b0;
   beat_t got_q[$];
   beat_t exp_q[$];

   axi_stream_insert_header #(.DATA_WD(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .valid_in      (valid_in),
      .ready_in      (ready_in),
      .data_in       (data_in),
      .keep_in       (keep_in),
      .last_in       (last_in),
      .valid_insert  (valid_insert),
      .ready_insert  (ready_insert),
      .header_insert (header_insert),
      .keep_insert   (keep_insert),
      .valid_out     (valid_out),
      .ready_out     (ready_out),
      .data_out      (data_out),
      .keep_out      (keep_out),
      .last_out      (last_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Downstream ready: random when requested, otherwise always ready.
   initial begin
      ready_out = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: records accepted beats and checks stability while stalled.
   logic        prev_stall = 1'b0;
   beat_t       prev_beat;
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            check("stall_valid", 64'(valid_out), 64'(1'b1));
            check("stall_beat", 64'({last_out, keep_out, data_out}), 64'(prev_beat));
         end
         if (valid_out && ready_out) got_q.push_back({last_out, keep_out, data_out});
         prev_stall = valid_out && !ready_out;
         prev_beat  = {last_out, keep_out, data_out};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic send_header(input logic [31:0] h, input logic [3:0] k);
      int n = 0;
      valid_insert  = 1'b1;
      header_insert = h;
      keep_insert   = k;
      do begin
         @(negedge clk);
         n++;
      end while (!ready_insert && n < 500);
      check("hdr_handshake", 64'(ready_insert), 64'(1'b1));
      @(posedge clk);
      #1;
      valid_insert = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n = 0;
      valid_in = 1'b1;
      data_in  = d;
      keep_in  = k;
      last_in  = l;
      do begin
         @(negedge clk);
         n++;
      end while (!ready_in && n < 500);
      check("beat_handshake", 64'(ready_in), 64'(1'b1));
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
      exp_q.push_back({l, k, d});
   endtask

   task automatic check_stream(input string tag);
      beat_t g;
      beat_t e;
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         $display("[TB] %s beat data=%h keep=%b last=%b", tag, g.data, g.keep, g.last);
         check({tag, "_data"}, 64'(g.data), 64'(e.data));
         check({tag, "_keep"}, 64'(g.keep), 64'(e.keep));
         check({tag, "_last"}, 64'(g.last), 64'(e.last));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Repack a packet's byte list into expected full-width beats.
   task automatic model_packet(input logic [7:0] bytes[$]);
      int          idx = 0;
      int          cnt;
      logic [31:0] d;
      logic [3:0]  k;
      while (idx < bytes.size()) begin
         cnt = (bytes.size() - idx >= 4) ? 4 : bytes.size() - idx;
         d = '0;
         k = '0;
         for (int j = 0; j < cnt; j++) begin
            d[31-8*j -: 8] = bytes[idx+j];
            k[3-j]         = 1'b1;
         end
         idx += cnt;
         push_exp(d, k, idx == bytes.size());
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      logic [3:0]  hk_opts[5];
      logic [3:0]  lk_opts[4];
      logic [7:0]  pkt_bytes[$];
      logic [31:0] h;
      logic [31:0] d;
      logic [3:0]  k;
      int          nb;

      hk_opts = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
      lk_opts = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};

      rst_n = 1'b0;
      valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
      valid_insert = 1'b0; header_insert = '0; keep_insert = '0;
      settle(2);

      // Reset state.
      check("rst_valid_out", 64'(valid_out), 64'(1'b0));
      check("rst_last_out", 64'(last_out), 64'(1'b0));
      check("rst_data_out", 64'(data_out), 64'(32'h0));
      check("rst_keep_out", 64'(keep_out), 64'(4'h0));
      check("rst_ready_insert", 64'(ready_insert), 64'(1'b1));
      check("rst_ready_in", 64'(ready_in), 64'(1'b0));
      rst_n = 1'b1;
      settle(1);

      // 1: two-byte header, second beat completes exactly.
      send_header(32'h11223344, 4'b0011);
      send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
      send_beat(32'hEEFF0011, 4'b1100, 1'b1);
      push_exp(32'h3344AABB, 4'b1111, 1'b0);
      push_exp(32'hCCDDEEFF, 4'b1111, 1'b1);
      settle(4);
      check_stream("t1");

      // 2: overflow on the last beat needs a flush beat.
      send_header(32'h11223344, 4'b0011);
      send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
      send_beat(32'h55667788, 4'b1110, 1'b1);
      push_exp(32'h3344AABB, 4'b1111, 1'b0);
      push_exp(32'hCCDD5566, 4'b1111, 1'b0);
      push_exp(32'h77000000, 4'b1000, 1'b1);
      settle(4);
      check_stream("t2");

      // 3: empty header, single partial beat, one-cycle latency.
      send_header(32'h12345678, 4'b0000);
      send_beat(32'hDEADBEEF, 4'b1000, 1'b1);
      check("t3_latency_valid", 64'(valid_out), 64'(1'b1));
      check("t3_latency_data", 64'(data_out), 64'(32'hDE000000));
      push_exp(32'hDE000000, 4'b1000, 1'b1);
      settle(4);
      check_stream("t3");

      // 4: full header, full last beat spills into a flush beat.
      send_header(32'hCAFEF00D, 4'b1111);
      send_beat(32'h01020304, 4'b1111, 1'b1);
      push_exp(32'hCAFEF00D, 4'b1111, 1'b0);
      push_exp(32'h01020304, 4'b1111, 1'b1);
      settle(4);
      check_stream("t4");

      // 5a: payload without a header is never accepted.
      valid_in = 1'b1;
      data_in  = 32'h99887766;
      keep_in  = 4'b1111;
      last_in  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("t5_no_hdr_ready_in", 64'(ready_in), 64'(1'b0));
         check("t5_no_hdr_valid_out", 64'(valid_out), 64'(1'b0));
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;

      // 5b: random packets under random backpressure against a byte model.
      rand_ready = 1'b1;
      for (int p = 0; p < 6; p++) begin
         pkt_bytes.delete();
         k  = hk_opts[p % 5];
         h  = $urandom;
         send_header(h, k);
         for (int i = 3; i >= 0; i--) begin
            if (k[i]) pkt_bytes.push_back(h[8*i +: 8]);
         end
         nb = 1 + (p % 3);
         for (int b = 0; b < nb; b++) begin
            d = $urandom;
            k = (b == nb - 1) ? lk_opts[$urandom_range(0, 3)] : 4'b1111;
            send_beat(d, k, b == nb - 1);
            for (int i = 3; i >= 0; i--) begin
               if (k[i]) pkt_bytes.push_back(d[8*i +: 8]);
            end
         end
         model_packet(pkt_bytes);
      end
      rand_ready = 1'b0;
      settle(20);
      check_stream("t5");

      // 6: reset mid-packet drops it; the next packet is clean.
      send_header(32'h11223344, 4'b0011);
      send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
      rst_n = 1'b0;
      settle(1);
      check("t6_rst_valid_out", 64'(valid_out), 64'(1'b0));
      check("t6_rst_ready_insert", 64'(ready_insert), 64'(1'b1));
      check("t6_rst_ready_in", 64'(ready_in), 64'(1'b0));
      rst_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      settle(1);
      send_header(32'h11223344, 4'b0011);
      send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
      send_beat(32'hEEFF0011, 4'b1100, 1'b1);
      push_exp(32'h3344AABB, 4'b1111, 1'b0);
      push_exp(32'hCCDDEEFF, 4'b1111, 1'b1);
      settle(4);
      check_stream("t6");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
